fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 81 ++++++++
 tb/tb_fetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-stage instruction fetch with local instruction memory, stall-captured redirects and bubble insertion
module fetch_unit #(
    parameter int                XLEN    = 32,
    parameter int                PC_W    = 5,
    parameter logic [PC_W-1:0]   BOOT_PC = '0,
    parameter logic [XLEN-1:0]   NOP     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             jump,
    input  logic [PC_W-1:0]  jumpPC,
    input  logic             trapPC,
    input  logic             imemWe,
    input  logic [PC_W-1:0]  imemWaddr,
    input  logic [XLEN-1:0]  imemWdata,
    output logic [XLEN-1:0]  insReg,
    output logic             insValid,
    output logic [PC_W-1:0]  insPC,
    output logic             redirPending,
    output logic [31:0]      fetchCount
);

    localparam int DEPTH = 2 ** PC_W;

    // Memory is deliberately outside the reset domain; the declaration initialiser gives a zeroed image.
    logic [XLEN-1:0] mem [DEPTH] = '{default: '0};

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] redirTarget;
    logic [XLEN-1:0] rdata;

    assign rdata = mem[pc];

    // The read above sees the pre-write word, so a same-cycle write to pc shows up one fetch later.
    always_ff @(posedge clk) begin
        if (imemWe) begin
            mem[imemWaddr] <= imemWdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc           <= BOOT_PC;
            redirTarget  <= '0;
            insReg       <= NOP;
            insValid     <= 1'b0;
            insPC        <= '0;
            redirPending <= 1'b0;
            fetchCount   <= '0;
        end else if (enable) begin
            if (jump) begin
                pc           <= jumpPC;
                insReg       <= NOP;
                insValid     <= 1'b0;
                redirPending <= 1'b0;
            end else if (redirPending) begin
                pc           <= redirTarget;
                insReg       <= NOP;
                insValid     <= 1'b0;
                redirPending <= 1'b0;
            end else if (trapPC) begin
                insReg   <= NOP;
                insValid <= 1'b0;
            end else begin
                insReg   <= rdata;
                insPC    <= pc;
                insValid <= 1'b1;
                pc       <= pc + PC_W'(1);
                if (fetchCount != 32'hFFFF_FFFF) begin
                    fetchCount <= fetchCount + 32'd1;
                end
            end
        end else if (jump) begin
            // Stalled redirect: remember the latest target and apply it on the next enabled cycle.
            redirTarget  <= jumpPC;
            redirPending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit against a behavioural fetch model
module tb_fetch_unit;

    localparam int          XLEN  = 32;
    localparam int          PC_W  = 5;
    localparam int          DEPTH = 32;
    localparam logic [4:0]  BOOT  = 5'd0;
    localparam logic [31:0] NOPV  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, enable, jump, trapPC, imemWe;
    logic [4:0]  jumpPC, imemWaddr;
    logic [31:0] imemWdata;
    logic [31:0] insReg;
    logic        insValid;
    logic [4:0]  insPC;
    logic        redirPending;
    logic [31:0] fetchCount;

    fetch_unit #(.XLEN(XLEN), .PC_W(PC_W), .BOOT_PC(BOOT), .NOP(NOPV)) dut (
        .clk(clk), .reset(reset), .enable(enable), .jump(jump), .jumpPC(jumpPC),
        .trapPC(trapPC), .imemWe(imemWe), .imemWaddr(imemWaddr), .imemWdata(imemWdata),
        .insReg(insReg), .insValid(insValid), .insPC(insPC),
        .redirPending(redirPending), .fetchCount(fetchCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic        val;
        logic [4:0]  ipc;
        logic        pend;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic [31:0] m_mem [DEPTH];
    int          m_pc, m_tgt, m_ipc;
    logic [31:0] m_ins, m_cnt;
    logic        m_val, m_pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Applies one cycle of stimulus and records what the outputs must be after that edge.
    task automatic step(input logic rst, input logic en, input logic j, input logic [4:0] jpc,
                        input logic tr, input logic we, input logic [4:0] wa, input logic [31:0] wd);
        logic [31:0] fetched;
        exp_t e;
        @(negedge clk);
        reset = rst; enable = en; jump = j; jumpPC = jpc; trapPC = tr;
        imemWe = we; imemWaddr = wa; imemWdata = wd;
        if (rst) begin
            m_pc = int'(BOOT); m_ins = NOPV; m_val = 1'b0; m_ipc = 0; m_pend = 1'b0; m_cnt = 0;
        end else begin
            fetched = m_mem[m_pc];
            if (en) begin
                if (j) begin
                    m_pc = int'(jpc); m_ins = NOPV; m_val = 1'b0; m_pend = 1'b0;
                end else if (m_pend) begin
                    m_pc = m_tgt; m_ins = NOPV; m_val = 1'b0; m_pend = 1'b0;
                end else if (tr) begin
                    m_ins = NOPV; m_val = 1'b0;
                end else begin
                    m_ins = fetched; m_ipc = m_pc; m_val = 1'b1;
                    m_pc = (m_pc + 1) % DEPTH;
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                end
            end else if (j) begin
                m_tgt = int'(jpc); m_pend = 1'b1;
            end
        end
        if (we) m_mem[wa] = wd;
        e.ins = m_ins; e.val = m_val; e.ipc = 5'(m_ipc); e.pend = m_pend; e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (insReg !== e.ins || insValid !== e.val || insPC !== e.ipc ||
                    redirPending !== e.pend || fetchCount !== e.cnt) begin
                    miscompares++;
                    $display("FAIL cycle t=%0t: got ins=%h val=%b pc=%0d pend=%b cnt=%0d expected ins=%h val=%b pc=%0d pend=%b cnt=%0d",
                             $time, insReg, insValid, insPC, redirPending, fetchCount,
                             e.ins, e.val, e.ipc, e.pend, e.cnt);
                end
            end
        end
    end

    initial begin : driver
        int budget;
        reset = 1'b1; enable = 1'b0; jump = 1'b0; jumpPC = '0; trapPC = 1'b0;
        imemWe = 1'b0; imemWaddr = '0; imemWdata = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_tgt = 0;

        // Load the image under reset: A,B,C at 0..2, random elsewhere.
        step(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 32'hAAAA_0000);
        step(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd1, 32'hBBBB_0001);
        step(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd2, 32'hCCCC_0002);
        for (int i = 3; i < DEPTH; i++)
            step(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'(i), $urandom);

        // Sequential A,B,C.
        run(3);
        // Jump at PC=4 to 22 then run.
        run(1);
        step(1'b0, 1'b1, 1'b1, 5'd22, 1'b0, 1'b0, 5'd0, 32'd0);
        run(3);
        // Wrap 29..31 -> 0.
        step(1'b0, 1'b1, 1'b1, 5'd29, 1'b0, 1'b0, 5'd0, 32'd0);
        run(5);
        // Stalled redirect to 12, with an idle stall cycle.
        step(1'b0, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        run(3);
        // Later jump during the same stall overwrites the target.
        step(1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 5'd18, 1'b0, 1'b0, 5'd0, 32'd0);
        run(2);
        // Trap two cycles, then trap together with jump.
        step(1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0);
        run(1);
        step(1'b0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 32'd0);
        run(2);
        // Write to the word being fetched: old data now, new data on a later visit.
        step(1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 32'h1234_5678);
        step(1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 5'd0, 32'd0);
        run(2);

        // Reset mid-run with a pending redirect; outputs must clear without a clock edge.
        step(1'b0, 1'b0, 1'b1, 5'd25, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("async_insReg", insReg, NOPV);
        chk("async_insValid", 32'(insValid), 32'd0);
        chk("async_insPC", 32'(insPC), 32'd0);
        chk("async_redirPending", 32'(redirPending), 32'd0);
        chk("async_fetchCount", fetchCount, 32'd0);
        run(4);

        // Randomised traffic, including occasional resets.
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 80) == 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 7) == 0), 5'($urandom), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 3) == 0), 5'($urandom), $urandom);
        run(3);

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
